// File: rtl/maroc_sc_receiver.sv
// maroc_sc_receiver: FPGA-side receiver for the MAROC slow-control serial link.
// It synchronises CK_SC, D_SC and RSTn_SC to CK_in and detects falling edges of
// the synchronised CK_SC. On each falling edge it shifts one bit into a FRAME_LEN
// shift register, LSB first, and latches every complete frame into sc_frame.
// Optional feature: define MAROC_SC_READBACK_EN to add the Q_SC readback output,
// a registered copy of the bit that is being shifted out.
module maroc_sc_receiver #(
  parameter int FRAME_LEN   = 829,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 10
) (
  input  logic                 CK_in,
  input  logic                 RSTn,
  input  logic                 CK_SC,
  input  logic                 D_SC,
  input  logic                 RSTn_SC,
  output logic [FRAME_LEN-1:0] sc_frame,
  output logic                 frame_valid,
  output logic [CNT_W-1:0]     bit_cnt,
  output logic                 err_short,
  output logic                 busy
`ifdef MAROC_SC_READBACK_EN
  ,
  output logic                 Q_SC
`endif
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] ck_sync_q, d_sync_q, rst_sync_q;
  logic                   ck_prev_q, rst_prev_q;
  logic                   ck_s, d_s, rst_s;
  logic                   ck_fall, rst_fall, link_rst;

  state_t                 state_q, state_d;
  logic [FRAME_LEN-1:0]   shreg_q, shreg_d;
  logic [FRAME_LEN-1:0]   frame_q, frame_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  // Synchronisers; CK_SC and RSTn_SC idle high so they reset to 1 and no false edge appears on release.
  always_ff @(posedge CK_in or negedge RSTn) begin
    if (!RSTn) begin
      ck_sync_q  <= '1;
      rst_sync_q <= '1;
      d_sync_q   <= '0;
      ck_prev_q  <= 1'b1;
      rst_prev_q <= 1'b1;
    end else begin
      ck_sync_q  <= {ck_sync_q[SYNC_STAGES-2:0], CK_SC};
      rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], RSTn_SC};
      d_sync_q   <= {d_sync_q[SYNC_STAGES-2:0], D_SC};
      ck_prev_q  <= ck_s;
      rst_prev_q <= rst_s;
    end
  end

  assign ck_s     = ck_sync_q[SYNC_STAGES-1];
  assign d_s      = d_sync_q[SYNC_STAGES-1];
  assign rst_s    = rst_sync_q[SYNC_STAGES-1];
  assign ck_fall  = ck_prev_q & ~ck_s;
  assign rst_fall = rst_prev_q & ~rst_s;
  assign link_rst = ~rst_s;

  // FSM state, shift register, counter and output registers.
  always_ff @(posedge CK_in or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      shreg_q <= '0;
      frame_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: a link reset overrides any coincident edge; the last bit latches the frame.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (link_rst) begin
      shreg_d = '0;
      cnt_d   = '0;
      state_d = IDLE;
      // A reset that lands on the final edge is not reported as a short frame.
      err_d   = rst_fall && (cnt_q != '0) && !(ck_fall && (cnt_q == LAST_BIT));
    end else if (ck_fall) begin
      shreg_d = {d_s, shreg_q[FRAME_LEN-1:1]};
      case (state_q)
        IDLE: begin
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
        SHIFT: begin
          if (cnt_q == LAST_BIT) begin
            frame_d = shreg_d;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign sc_frame    = frame_q;
  assign frame_valid = valid_q;
  assign bit_cnt     = cnt_q;
  assign err_short   = err_q;
  assign busy        = (state_q == SHIFT);

`ifdef MAROC_SC_READBACK_EN
  logic q_sc_q;

  // Readback: registered copy of the bit at the output end of the shift register.
  always_ff @(posedge CK_in or negedge RSTn) begin
    if (!RSTn) begin
      q_sc_q <= 1'b0;
    end else if (link_rst) begin
      q_sc_q <= 1'b0;
    end else begin
      q_sc_q <= shreg_q[0];
    end
  end

  assign Q_SC = q_sc_q;
`endif

endmodule

// File: tb/tb_maroc_sc_receiver.sv
// tb_maroc_sc_receiver: table-driven bench with a frame scoreboard for maroc_sc_receiver.
// CK_SC runs at CK_in/4 and idles high. D_SC changes while CK_SC is high.
// Expected frames are queued when they are sent and are popped on frame_valid.
module tb_maroc_sc_receiver;
  localparam int FL = 829;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rstn;
  logic          ck_sc, d_sc, rstn_sc;
  logic [FL-1:0] sc_frame;
  logic          frame_valid, err_short, busy;
  logic [CW-1:0] bit_cnt;
`ifdef MAROC_SC_READBACK_EN
  logic          q_sc;
`endif

  always #5 clk = ~clk;

  maroc_sc_receiver #(.FRAME_LEN(FL), .SYNC_STAGES(2), .CNT_W(CW)) dut (
    .CK_in      (clk),
    .RSTn       (rstn),
    .CK_SC      (ck_sc),
    .D_SC       (d_sc),
    .RSTn_SC    (rstn_sc),
    .sc_frame   (sc_frame),
    .frame_valid(frame_valid),
    .bit_cnt    (bit_cnt),
    .err_short  (err_short),
    .busy       (busy)
`ifdef MAROC_SC_READBACK_EN
    ,
    .Q_SC       (q_sc)
`endif
  );

  typedef struct {
    logic [FL-1:0] data;
    int            nbits;   // bits sent; fewer than FL means a partial frame
    bit            abort;   // pulse RSTn_SC low after the bits are sent
    bit            settle;  // idle afterwards and check the counters
  } vec_t;

  localparam int NV = 13;
  vec_t          vecs[NV];

  int            errors = 0, checks = 0;
  int            valid_cnt = 0, err_cnt = 0, exp_valid = 0, exp_err = 0;
  logic [FL-1:0] sb_q[$];
  logic [FL-1:0] last_frame = '0;
  logic [FL-1:0] rb_frame = '0;
  bit            rb_on = 1'b0;
  int            rb_idx = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_frame(input string name, input logic [FL-1:0] act, input logic [FL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got low64=%h expected low64=%h (%0d bits differ)",
               name, act[63:0], exp[63:0], $countones(act ^ exp));
    end
  endtask

  // One CK_in cycle; outputs are sampled on the falling edge and frame_valid pops the scoreboard.
  task automatic cyc();
    @(negedge clk);
    if (frame_valid === 1'b1) begin
      valid_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_valid: got 1 expected 0");
      end else begin
        check_frame("sc_frame", sc_frame, sb_q.pop_front());
      end
    end
    if (err_short === 1'b1) err_cnt++;
  endtask

  task automatic send_bit(input logic b);
    d_sc = b;
    cyc();
    cyc();
`ifdef MAROC_SC_READBACK_EN
    if (rb_on) begin
      rb_frame[rb_idx] = q_sc;
      rb_idx++;
    end
`endif
    ck_sc = 1'b0;
    cyc();
    cyc();
    ck_sc = 1'b1;
  endtask

  task automatic send_frame(input logic [FL-1:0] data, input int nbits);
    if (nbits == FL) begin
      sb_q.push_back(data);
      last_frame = data;
      exp_valid++;
    end
    for (int i = 0; i < nbits; i++) send_bit(data[i]);
  endtask

  function automatic logic [FL-1:0] rand_frame();
    logic [FL-1:0] f;
    for (int i = 0; i < FL; i++) f[i] = 1'($urandom_range(0, 1));
    return f;
  endfunction

  initial begin
    logic [FL-1:0] f;

    // Stimulus table.
    f = '0;
    f[0] = 1'b1;
    f[12:3] = 10'h2A5;
    f[154:27] = 128'hDEADBEEF_01234567_89ABCDEF_0BADBEEF;
    vecs[0] = '{data: f, nbits: FL, abort: 1'b0, settle: 1'b1};
    vecs[1] = '{data: '1, nbits: FL, abort: 1'b0, settle: 1'b0};
    for (int i = 0; i < FL; i++) f[i] = (i % 2 == 1);
    vecs[2] = '{data: f, nbits: FL, abort: 1'b0, settle: 1'b1};
    vecs[3] = '{data: rand_frame(), nbits: 400, abort: 1'b1, settle: 1'b1};
    for (int v = 4; v < NV; v++) vecs[v] = '{data: rand_frame(), nbits: FL, abort: 1'b0, settle: 1'b1};

    // Reset state.
    rstn = 1'b1; ck_sc = 1'b1; d_sc = 1'b0; rstn_sc = 1'b1;
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_frame("reset_sc_frame", sc_frame, '0);
    check("reset_bit_cnt", 64'(bit_cnt), 64'd0);
    check("reset_frame_valid", 64'(frame_valid), 64'd0);
    check("reset_err_short", 64'(err_short), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    rstn = 1'b1;
    repeat (2) cyc();

    // Table-driven frames; vectors 1 and 2 run back to back with no gap.
    for (int v = 0; v < NV; v++) begin
      send_frame(vecs[v].data, vecs[v].nbits);
      if (vecs[v].abort) begin
        repeat (4) cyc();
        check($sformatf("v%0d_partial_bit_cnt", v), 64'(bit_cnt), 64'(vecs[v].nbits));
        check($sformatf("v%0d_partial_busy", v), 64'(busy), 64'd1);
        rstn_sc = 1'b0;
        repeat (16) cyc();
        check($sformatf("v%0d_linkrst_bit_cnt", v), 64'(bit_cnt), 64'd0);
        rstn_sc = 1'b1;
        repeat (4) cyc();
        if (vecs[v].nbits > 0 && vecs[v].nbits < FL) exp_err++;
      end
      if (vecs[v].settle) begin
        repeat (6) cyc();
        check($sformatf("v%0d_bit_cnt", v), 64'(bit_cnt), 64'd0);
        check($sformatf("v%0d_busy", v), 64'(busy), 64'd0);
        check($sformatf("v%0d_valid_count", v), 64'(valid_cnt), 64'(exp_valid));
        check($sformatf("v%0d_err_short_count", v), 64'(err_cnt), 64'(exp_err));
      end
    end

    // RSTn asserted mid-frame at bit 500: all state clears at once.
    f = rand_frame();
    send_frame(f, 500);
    repeat (4) cyc();
    check("midrst_bit_cnt_before", 64'(bit_cnt), 64'd500);
    #3 rstn = 1'b0;
    #1;
    check_frame("midrst_sc_frame", sc_frame, '0);
    check("midrst_bit_cnt", 64'(bit_cnt), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    last_frame = '0;
    repeat (3) cyc();
    f = rand_frame();
    send_frame(f, FL);
    repeat (6) cyc();
    check("midrst_valid_count", 64'(valid_cnt), 64'(exp_valid));
    check_frame("midrst_next_frame", sc_frame, f);

    // Link reset coinciding with the final edge: no frame, no err_short.
    f = rand_frame();
    send_frame(f, FL - 1);
    d_sc = f[FL-1];
    cyc();
    cyc();
    ck_sc = 1'b0;
    rstn_sc = 1'b0;
    cyc();
    cyc();
    ck_sc = 1'b1;
    repeat (16) cyc();
    rstn_sc = 1'b1;
    repeat (4) cyc();
    check("collide_valid_count", 64'(valid_cnt), 64'(exp_valid));
    check("collide_err_short_count", 64'(err_cnt), 64'(exp_err));
    check("collide_bit_cnt", 64'(bit_cnt), 64'd0);
    check_frame("collide_sc_frame_held", sc_frame, last_frame);

`ifdef MAROC_SC_READBACK_EN
    // Readback: while frame Y is shifted in, Q_SC replays frame X in order.
    f = rand_frame();
    send_frame(f, FL);
    rb_idx = 0;
    rb_on = 1'b1;
    send_frame(rand_frame(), FL);
    rb_on = 1'b0;
    repeat (6) cyc();
    check_frame("readback_q_sc", rb_frame, f);
`endif

    check("final_scoreboard_empty", 64'(sb_q.size()), 64'd0);
    check("final_valid_count", 64'(valid_cnt), 64'(exp_valid));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
